// File: rtl/etc_tile_sched.sv
// etc_tile_sched: issue scheduler for the etcEX tile datapath.
// Accepts a job (op, k_tiles), issues k_tiles A/B tile pairs as they arrive,
// waits ETC_LAT cycles for the datapath to drain, then presents the result
// until the consumer handshakes it.
// Optional build macro: ETC_SCHED_PERF_CNT_EN enables the RUN-state
// starvation counter on stall_cnt; otherwise stall_cnt is tied to zero.
module etc_tile_sched #(
  parameter int unsigned ETC_LAT = 1,
  parameter int unsigned KW      = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [KW-1:0] k_tiles,
  input  logic          abort,
  input  logic          tile_valid,
  output logic          tile_ready,
  output logic [1:0]    etc_op,
  output logic          etc_issue,
  output logic          acc_first,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          err,
  output logic [15:0]   stall_cnt
);

  localparam int unsigned CW = KW + 1;
  localparam int unsigned DW = 4;
  localparam logic [1:0]  OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [CW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_drain;
  logic          r_first;
  logic          r_err;

  logic          w_accept;
  logic          w_reject;
  logic          w_issue;
  logic          w_last;
  logic [CW-1:0] w_k_ext;
  logic [CW-1:0] w_cnt_inc;

  // Job request decode and issue qualification
  assign w_accept  = (r_state == S_IDLE) & start & (op != OP_RSVD) & ~abort;
  assign w_reject  = (r_state == S_IDLE) & start & (op == OP_RSVD) & ~abort;
  assign w_issue   = tile_valid & tile_ready;
  assign w_cnt_inc = r_cnt + CW'(1);
  assign w_last    = w_issue & (w_cnt_inc == r_k);
  // k_tiles of zero encodes the full 2^KW tiles
  assign w_k_ext   = (k_tiles == '0) ? (CW'(1) << KW) : {1'b0, k_tiles};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_drain <= DW'(1)) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  // Job context: latched op/k, issue counter, first-issue flag, drain timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 2'b00;
      r_k     <= '0;
      r_cnt   <= '0;
      r_drain <= '0;
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_accept) begin
        r_op    <= op;
        r_k     <= w_k_ext;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end else if (w_issue && !abort) begin
        r_cnt   <= w_cnt_inc;
        r_first <= 1'b0;
        if (w_last) r_drain <= DW'(ETC_LAT);
      end else if ((r_state == S_DRAIN) && (r_drain != '0)) begin
        r_drain <= r_drain - DW'(1);
      end
    end
  end

  // Outputs decoded from state so reset clears them without a clock edge
  assign tile_ready = (r_state == S_RUN);
  assign etc_issue  = w_issue;
  assign acc_first  = w_issue & r_first;
  assign res_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);
  assign err        = r_err;
  assign etc_op     = busy ? r_op : 2'b00;

`ifdef ETC_SCHED_PERF_CNT_EN
  logic [15:0] r_stall;

  // Saturating count of RUN cycles with no tile offered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= 16'h0000;
    end else if (w_accept) begin
      r_stall <= 16'h0000;
    end else if ((r_state == S_RUN) && !tile_valid && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign stall_cnt = r_stall;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_etc_tile_sched.sv
// Self-checking bench for etc_tile_sched: table-driven jobs with a result
// scoreboard, plus directed sequences for reject, abort and mid-job reset.
module tb_etc_tile_sched;

  localparam int unsigned ETC_LAT = 1;
  localparam int unsigned KW      = 4;
`ifdef ETC_SCHED_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    op;
  logic [KW-1:0] k_tiles;
  logic          abort;
  logic          tile_valid;
  logic          tile_ready;
  logic [1:0]    etc_op;
  logic          etc_issue;
  logic          acc_first;
  logic          res_valid;
  logic          res_ready;
  logic          busy;
  logic          err;
  logic [15:0]   stall_cnt;

  etc_tile_sched #(.ETC_LAT(ETC_LAT), .KW(KW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .k_tiles(k_tiles),
    .abort(abort), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .etc_op(etc_op), .etc_issue(etc_issue), .acc_first(acc_first),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy), .err(err),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    op;
    logic [KW-1:0] k;
    logic [15:0]   pat;        // tile_valid per cycle after accept, bit i = cycle i
    int            pat_len;
    int            rdy_delay;  // cycles res_ready stays low once DONE
    bit            start_at_hs;
    int            exp_issues;
    int            exp_stall;  // with the perf counter enabled
  } vec_t;

  typedef struct {
    logic [1:0] op;
    int         issues;
    int         stall;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: counts issues of the live job, checks latency, pops scoreboard
  int   m_issues = 0;
  int   m_firsts = 0;
  int   m_last_cyc = 0;
  logic m_prev_rv = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (!busy) begin
      m_issues = 0;
      m_firsts = 0;
    end
    if (etc_issue && !abort) begin
      m_issues++;
      m_last_cyc = cyc;
      if (acc_first) m_firsts++;
    end
    if (res_valid && !m_prev_rv)
      check("res_latency", 32'(cyc - m_last_cyc), 32'(ETC_LAT + 1));
    if (res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_etc_op", 32'(etc_op), 32'(e.op));
        check("sb_issues", 32'(m_issues), 32'(e.issues));
        check("sb_acc_first_count", 32'(m_firsts), 32'd1);
        check("sb_stall_cnt", 32'(stall_cnt), 32'(e.stall));
      end
    end
    m_prev_rv = res_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input vec_t v);
    sb_t e;
    int  i;
    start = 1'b1; op = v.op; k_tiles = v.k;
    step();
    start = 1'b0;
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_etc_op", 32'(etc_op), 32'(v.op));
    e.op = v.op; e.issues = v.exp_issues; e.stall = PERF ? v.exp_stall : 0;
    sb_q.push_back(e);
    i = 0;
    while (!res_valid && i < 64) begin
      tile_valid = v.pat[i % v.pat_len];
      i++;
      step();
    end
    tile_valid = 1'b0;
    if (!res_valid) check("res_valid_timeout", 32'd0, 32'd1);
    repeat (v.rdy_delay) begin
      check("res_valid_hold", 32'(res_valid), 32'd1);
      step();
    end
    res_ready = 1'b1;
    if (v.start_at_hs) begin start = 1'b1; op = 2'b01; k_tiles = KW'(2); end
    step();
    res_ready = 1'b0; start = 1'b0;
    check("idle_after_handshake", 32'(busy), 32'd0);
    step();
    check("still_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tile_ready"}, 32'(tile_ready), 32'd0);
    check({tag, "_etc_issue"},  32'(etc_issue),  32'd0);
    check({tag, "_acc_first"},  32'(acc_first),  32'd0);
    check({tag, "_res_valid"},  32'(res_valid),  32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_err"},        32'(err),        32'd0);
    check({tag, "_etc_op"},     32'(etc_op),     32'd0);
    check({tag, "_stall_cnt"},  32'(stall_cnt),  32'd0);
  endtask

  initial begin
    //            op     k      pat       len rdy hs  iss stall
    vecs[0] = '{2'b00, 4'd4,  16'h0001, 1,  0,  0,  4,  0};
    vecs[1] = '{2'b10, 4'd0,  16'h0001, 1,  5,  0,  16, 0};
    vecs[2] = '{2'b01, 4'd3,  16'h0029, 6,  1,  1,  3,  3};
    vecs[3] = '{2'b01, 4'd1,  16'h0001, 1,  0,  0,  1,  0};
    vecs[4] = '{2'b00, 4'd2,  16'h0002, 2,  2,  0,  2,  2};
    vecs[5] = '{2'b10, 4'd15, 16'h0001, 1,  0,  1,  15, 0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; k_tiles = '0; abort = 1'b0;
    tile_valid = 1'b0; res_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    step();

    for (int n = 0; n < 6; n++) run_job(vecs[n]);

    // Reserved op: one-cycle err, no job, no issue
    tile_valid = 1'b1; start = 1'b1; op = 2'b11; k_tiles = KW'(4);
    step();
    start = 1'b0;
    check("rsvd_err_pulse", 32'(err), 32'd1);
    check("rsvd_busy", 32'(busy), 32'd0);
    check("rsvd_no_issue", 32'(etc_issue), 32'd0);
    step();
    check("rsvd_err_clear", 32'(err), 32'd0);
    check("rsvd_busy_later", 32'(busy), 32'd0);
    tile_valid = 1'b0;

    // Abort after the second of four issues
    start = 1'b1; op = 2'b00; k_tiles = KW'(4); tile_valid = 1'b1;
    step();
    start = 1'b0;
    check("abort_first_issue", 32'(acc_first), 32'd1);
    step();
    check("abort_second_issue", 32'(etc_issue), 32'd1);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0; tile_valid = 1'b0;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_no_err", 32'(err), 32'd0);
    repeat (3) begin
      check("abort_no_res_valid", 32'(res_valid), 32'd0);
      step();
    end
    run_job('{2'b01, 4'd2, 16'h0001, 1, 0, 0, 2, 0});

    // Asynchronous reset while draining
    start = 1'b1; op = 2'b10; k_tiles = KW'(1); tile_valid = 1'b1;
    step();
    start = 1'b0;
    step();
    tile_valid = 1'b0;
    check("drain_busy", 32'(busy), 32'd1);
    check("drain_no_res_valid", 32'(res_valid), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) step();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      step();
      check("post_reset_no_res_valid", 32'(res_valid), 32'd0);
      check("post_reset_idle", 32'(busy), 32'd0);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
